seq_alu: RTL

Parametrised multi-cycle ALU with an internal accumulator, a start/done handshake and an OFF/READY/RUN/ERROR control FSM. Generalises the fixed 8-bit accumulator ALU to any width N ≥ 4. Adds a shift-add multi-cycle multiplier, registered operand capture, and per-operation overflow detection. Sits between the operand/selector front-end and the result display path.

---
 rtl/seq_alu.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle accumulator ALU: start/done handshake, OFF/READY/RUN/ERROR control FSM, shift-add multiplier.
// Optional macro SEQ_ALU_SAT_EN: saturating ADD/SUB/MUL instead of wrap-around plus ERROR state.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             on,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             load_acc,
    input  logic [WIDTH-1:0] num_a,
    input  logic [WIDTH-1:0] num_b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] acc,
    output logic             done,
    output logic             busy,
    output logic             error,
    output logic [1:0]       state
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef SEQ_ALU_SAT_EN
    localparam bit satEn = 1'b1;
`else
    localparam bit satEn = 1'b0;
`endif

    localparam logic [2:0] opAnd = 3'b000;
    localparam logic [2:0] opOr  = 3'b001;
    localparam logic [2:0] opXor = 3'b010;
    localparam logic [2:0] opNot = 3'b011;
    localparam logic [2:0] opAdd = 3'b100;
    localparam logic [2:0] opSub = 3'b101;
    localparam logic [2:0] opMul = 3'b110;
    localparam logic [2:0] opClr = 3'b111;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        READY = 2'b01,
        RUN   = 2'b10,
        ERROR = 2'b11
    } stateT;

    stateT stateReg, stateNext;

    logic [WIDTH-1:0]   aReg, bReg, resultReg, accReg;
    logic [2:0]         opReg;
    logic [2*WIDTH-1:0] prodReg, mcandReg, prodNext;
    logic [CW-1:0]      cntReg;
    logic               doneReg, busyReg, errorReg;

    logic [WIDTH-1:0]   aSel, opValue, finalValue;
    logic [WIDTH:0]     sumWide, diffWide;
    logic               opComplete, opOverflow, startAccept, finishNow;

    assign aSel        = load_acc ? num_a : accReg;
    assign startAccept = (stateReg == READY) && on && start;
    assign finishNow   = (stateReg == RUN) && on && opComplete;

    // Operation result and overflow, evaluated on the captured operands.
    always_comb begin
        sumWide    = {1'b0, aReg} + {1'b0, bReg};
        diffWide   = {1'b0, aReg} - {1'b0, bReg};
        prodNext   = prodReg + (bReg[0] ? mcandReg : '0);
        opComplete = (opReg != opMul) || (cntReg == CW'(WIDTH - 1));
        opValue    = '0;
        opOverflow = 1'b0;
        case (opReg)
            opAnd: opValue = aReg & bReg;
            opOr:  opValue = aReg | bReg;
            opXor: opValue = aReg ^ bReg;
            opNot: opValue = ~aReg;
            opAdd: begin
                opValue    = sumWide[WIDTH-1:0];
                opOverflow = sumWide[WIDTH];
            end
            opSub: begin
                opValue    = diffWide[WIDTH-1:0];
                opOverflow = diffWide[WIDTH];
            end
            opMul: begin
                opValue    = prodNext[WIDTH-1:0];
                opOverflow = |prodNext[2*WIDTH-1:WIDTH];
            end
            opClr: opValue = '0;
            default: opValue = '0;
        endcase
        finalValue = opValue;
        if (satEn && opOverflow)
            finalValue = (opReg == opSub) ? '0 : '1;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            OFF:   if (on) stateNext = READY;
            READY: begin
                if (!on)
                    stateNext = OFF;
                else if (start)
                    stateNext = RUN;
            end
            RUN: begin
                if (!on)
                    stateNext = OFF;
                else if (opComplete)
                    stateNext = (opOverflow && !satEn) ? ERROR : READY;
            end
            ERROR: stateNext = on ? READY : OFF;
            default: stateNext = READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stateReg <= READY;
        else
            stateReg <= stateNext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aReg      <= '0;
            bReg      <= '0;
            opReg     <= '0;
            prodReg   <= '0;
            mcandReg  <= '0;
            cntReg    <= '0;
            resultReg <= '0;
            accReg    <= '0;
            doneReg   <= 1'b0;
            busyReg   <= 1'b0;
            errorReg  <= 1'b0;
        end else begin
            doneReg <= finishNow;
            busyReg <= (stateNext == RUN);
            if (startAccept) begin
                aReg     <= aSel;
                bReg     <= num_b;
                opReg    <= op;
                errorReg <= 1'b0;
                prodReg  <= '0;
                mcandReg <= {{WIDTH{1'b0}}, aSel};
                cntReg   <= '0;
            end else if (finishNow) begin
                resultReg <= finalValue;
                if (!opOverflow || satEn)
                    accReg <= finalValue;
                if (opOverflow)
                    errorReg <= 1'b1;
            end else if ((stateReg == RUN) && on) begin
                // One multiplier bit per cycle: B shifts right, multiplicand shifts left.
                prodReg  <= prodNext;
                mcandReg <= mcandReg << 1;
                bReg     <= bReg >> 1;
                cntReg   <= cntReg + 1'b1;
            end
        end
    end

    assign result = resultReg;
    assign acc    = accReg;
    assign done   = doneReg;
    assign busy   = busyReg;
    assign error  = errorReg;
    assign state  = stateReg;
endmodule
